// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

    localparam int unsigned SERIAL_ADDER_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder cell used as the serial adder's bit datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic half_sum;

    always_comb begin
        half_sum = a ^ b;
        sum      = half_sum ^ cin;
        cout     = (a & b) | (cin & half_sum);
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell, LSB first, carry held in a flop.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = SERIAL_ADDER_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum;
    logic             fa_cout;

    full_adder u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        cnt     <= '0;
                        sum     <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else begin
                        state   <= IDLE;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    sum     <= {fa_sum, sum[WIDTH-1:1]};
                    carry_q <= fa_cout;
                    if (cnt == LAST_BIT) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        cout  <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry_q here is the carry into the MSB; the XOR is registered directly
                        ovf   <= carry_q ^ fa_cout;
`endif
                        state <= DONE;
                    end else begin
                        cnt   <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus random operands vs an arithmetic model.
module tb_serial_adder;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer addition of the operands.
    task automatic check_result(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                                input logic icin);
        int unsigned tot;
        logic [31:0] tv;
        int          sv;
        tot = int'(ia) + int'(ib) + int'(icin);
        tv  = tot;
        sv  = int'($signed(ia)) + int'($signed(ib)) + int'(icin);
        check({tag, "_sum"}, 64'(sum), 64'(tv[W-1:0]));
        check({tag, "_cout"}, 64'(cout), 64'(tv[W]));
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, "_ovf"}, 64'(ovf),
              64'((sv > (2 ** (W - 1)) - 1) || (sv < -(2 ** (W - 1)))));
`else
        if (sv == 0) tv = 0;
`endif
    endtask

    // Presents operands with start for one cycle; returns during cycle 1 of RUN.
    task automatic launch(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic icin);
        @(negedge clk);
        a = ia; b = ib; cin = icin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic icin);
        launch(ia, ib, icin);
        for (int unsigned k = 1; k <= W; k++) begin
            check({tag, "_busy"}, 64'(busy), 64'd1);
            check({tag, "_nodone"}, 64'(done), 64'd0);
            @(negedge clk);
        end
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_idle"}, 64'(busy), 64'd0);
        check_result(tag, ia, ib, icin);
        @(negedge clk);
        check({tag, "_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int seen;
        int gap;
        logic [W-1:0] ra, rb;
        logic rc;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("a0f_b01", 8'h0F, 8'h01, 1'b0);
        check("a0f_b01_const", 64'({cout, sum}), 64'h010);
        run_op("aff_b01", 8'hFF, 8'h01, 1'b0);
        check("aff_b01_const", 64'({cout, sum}), 64'h100);
        run_op("a00_cin", 8'h00, 8'h00, 1'b1);
        check("a00_cin_const", 64'({cout, sum}), 64'h001);

`ifdef SERIAL_ADDER_OVF_EN
        run_op("a7f_b01", 8'h7F, 8'h01, 1'b0);
        check("a7f_b01_ovf_const", 64'({ovf, cout, sum}), 64'h280);
        run_op("a80_b80", 8'h80, 8'h80, 1'b0);
        check("a80_b80_ovf_const", 64'({ovf, cout, sum}), 64'h300);
        run_op("aff_b01_ovf", 8'hFF, 8'h01, 1'b0);
        check("aff_b01_ovf_const", 64'(ovf), 64'd0);
`endif

        // start pulsed during RUN must be ignored
        launch(8'h0F, 8'h01, 1'b0);
        for (int unsigned k = 1; k <= W; k++) begin
            if (k == 4) begin
                start = 1'b1; a = 8'hAA; b = 8'hAA; cin = 1'b1;
            end else begin
                start = 1'b0;
            end
            check("ign_busy", 64'(busy), 64'd1);
            @(negedge clk);
        end
        check("ign_done", 64'(done), 64'd1);
        check_result("ign", 8'h0F, 8'h01, 1'b0);
        seen = 0;
        repeat (2 * W) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        check("ign_no_second_op", 64'(seen), 64'd0);

        // start held through DONE: back-to-back accept
        @(negedge clk);
        a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 8'h55; b = 8'hAA; cin = 1'b1;
        for (int unsigned k = 1; k <= W; k++) begin
            check("b2b_busy1", 64'(busy), 64'd1);
            @(negedge clk);
        end
        check("b2b_done1", 64'(done), 64'd1);
        check_result("b2b_first", 8'h0F, 8'h01, 1'b0);
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy2", 64'(busy), 64'd1);
        gap = 1;
        while (done !== 1'b1 && gap < 20) begin
            @(negedge clk);
            gap++;
        end
        check("b2b_gap", 64'(gap), 64'(W + 1));
        check_result("b2b_second", 8'h55, 8'hAA, 1'b1);
        check("b2b_second_const", 64'({cout, sum}), 64'h100);

        // asynchronous reset in the middle of RUN
        launch(8'h0F, 8'h00, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_sum", 64'(sum), 64'd0);
        check("mid_rst_cout", 64'(cout), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("mid_rst_ovf", 64'(ovf), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (W + 3) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        check("post_rst_idle", 64'(seen), 64'd0);
        run_op("a12_b34", 8'h12, 8'h34, 1'b0);
        check("a12_b34_const", 64'({cout, sum}), 64'h046);

        repeat (25) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            run_op("rand", ra, rb, rc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial multi-bit adder wrapping the team's one-bit adder cell. It latches two WIDTH-bit operands and a carry-in on a start handshake. It then feeds the cell one bit pair per clock, LSB first, with the carry held in a flip-flop between cycles. It sits directly upstream of the `full_adder` cell: it sequences that cell's inputs and collects its sum/carry outputs into a result register.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal range 2..32.
- `clk`  input  1  rising-edge clock; single clock domain.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request; sampled only when `busy`=0.
- `a`  input  WIDTH  operand A; captured on an accepted start.
- `b`  input  WIDTH  operand B; captured on an accepted start.
- `cin`  input  1  initial carry; captured on an accepted start.
- `busy`  output  1  high while bits are being processed.
- `done`  output  1  one-cycle pulse when `sum`/`cout` become valid.
- `sum`  output  WIDTH  result; held until the next accepted start.
- `cout`  output  1  final carry out; held like `sum`.
- `ovf`  output  1  signed overflow. Present only with `SERIAL_ADDER_OVF_EN`.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `start`=1 → capture `a`, `b`, carry FF←`cin`.
  - Clear the bit counter and `sum`.
  - Go to RUN.
- RUN, each cycle:
  - Cell inputs = `a_q[0]`, `b_q[0]`, carry FF.
  - Shift `a_q`/`b_q` right by one.
  - Shift cell sum into `sum` MSB (right-shift fill), so bit i lands at `sum[i]` after WIDTH shifts.
  - Carry FF ← cell cout.
  - Counter increments; at count WIDTH-1 go to DONE.
- DONE:
  - `done`=1 for exactly this cycle.
  - `cout` = carry FF.
  - `start`=1 here is accepted exactly as in IDLE (back-to-back operation); otherwise go to IDLE.
- `start` while in RUN is ignored; there is no queueing.
- Arithmetic: {`cout`,`sum`} = `a` + `b` + `cin`, modulo 2^(WIDTH+1).
- Counter width is $clog2(WIDTH); it never wraps within an operation.
- Operand inputs may change freely after the accepting edge.
- Reset (any time, including mid-RUN) → IDLE; `busy`, `done`, `sum`, `cout`, `ovf`, carry FF and counter all 0. A partial result is discarded, not resumed.

## Timing
- `start` high in cycle 0 (accepted at the end of cycle 0).
- `busy`=1 in cycles 1..WIDTH; bit i is processed in cycle i+1.
- `done`=1 and results valid in cycle WIDTH+1; `busy`=0 in that cycle.
- Latency from accepted start to done is WIDTH+1 cycles. Throughput is one add per WIDTH+1 cycles when restarted from DONE.
- `sum` shows partial/shifting values while `busy`=1. Only sample it when `done`=1 or in IDLE afterwards.
- All outputs are registered; no combinational input-to-output path.

## Configuration
- `SERIAL_ADDER_OVF_EN` defined:
  - Add port `ovf` and a 1-bit register capturing the carry into the MSB (carry FF value during cycle WIDTH).
  - `ovf` = that value XOR final `cout`.
  - `ovf` updates and holds with `sum`, and resets to 0.
- Not defined: no `ovf` port and no extra register; behaviour is otherwise identical.

## Structure
- Package `serial_adder_pkg`: FSM state enum (IDLE/RUN/DONE), `SERIAL_ADDER_DEFAULT_WIDTH` = 8.
- One sub-module: a single `full_adder` instance for the bit datapath. No other arithmetic is inferred.

## Test plan
- WIDTH=8: a=0x0F, b=0x01, cin=0 → `done` in cycle 9, sum=0x10, cout=0; `busy` high exactly in cycles 1..8.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0x00, b=0x00, cin=1 → sum=0x01, cout=0.
- With `SERIAL_ADDER_OVF_EN`: a=0x7F, b=0x01 → sum=0x80, cout=0, ovf=1. Then a=0x80, b=0x80 → sum=0x00, cout=1, ovf=1. Then a=0xFF, b=0x01 → ovf=0.
- `start` pulsed in cycle 4 of a RUN with different operands → ignored; first result is unchanged and no second `done`.
- `start` held high through DONE → second op accepted; second `done` exactly 9 cycles after the first. Check 0x55+0xAA+1 → sum=0x00, cout=1.
- `rst_n` low in cycle 5 of RUN → all outputs 0 asynchronously. After release, state is IDLE, no `done` pulse, and a new 0x12+0x34 → 0x46.
